// File: rtl/uart_packet_rx.sv
// uart_packet_rx: hunts for SYNC_BYTE in the UART byte stream, parses
// SYNC, CMD, LEN, LEN payload bytes, CHK, buffers the payload of a packet
// whose 8-bit sum over CMD..CHK is zero, and holds it until acknowledged.
// Optional inter-byte timeout is built when UART_PKT_RX_TIMEOUT_EN is defined;
// otherwise o_Err_Timeout is tied low and a stalled packet waits forever.
module uart_packet_rx #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned TIMEOUT_CLKS = 43400
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    input  logic              i_Pkt_Ack,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Pkt_Valid,
    output logic [7:0]        o_Pkt_Cmd,
    output logic [7:0]        o_Pkt_Len,
    output logic              o_Err_Chk,
    output logic              o_Err_Len,
    output logic              o_Err_Timeout,
    output logic              o_Drop
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    // Reject parameter sets the buffer addressing or 16-bit counter cannot honour
    if (MAX_LEN < 1 || MAX_LEN > 255 || DEPTH < MAX_LEN ||
        TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 65535) begin : g_bad_params
        $error("uart_packet_rx: illegal parameter combination");
    end

    logic [2:0] state_q, state_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic [7:0] pkt_cmd_q, pkt_cmd_d;
    logic [7:0] pkt_len_q, pkt_len_d;
    logic       err_chk_q, err_chk_d;
    logic       err_len_q, err_len_d;
    logic       drop_q, drop_d;
    logic [7:0] rd_data_q, rd_data_d;

    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [7:0]        sum_next_c;
    logic              timeout_c;

    logic [7:0] buf_mem [DEPTH];

    assign sum_next_c = sum_q + i_Rx_Byte;

`ifdef UART_PKT_RX_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_tmo_q, err_tmo_d;
    logic        active_c;

    // Inter-byte gap counter; a byte arriving in the expiry cycle wins
    always_comb begin
        active_c  = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);
        timeout_c = active_c && !i_Rx_DV && (tmo_cnt_q == TMO_LAST);
        tmo_cnt_d = 16'd0;
        if (active_c && !i_Rx_DV && !timeout_c) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
        err_tmo_d = timeout_c;
    end

    // Timeout counter and pulse registers
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tmo_cnt_q <= 16'd0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign o_Err_Timeout = err_tmo_q;
`else
    assign timeout_c     = 1'b0;
    assign o_Err_Timeout = 1'b0;
`endif

    // Frame parser: next state, running sum, held-packet fields and pulses
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        idx_d       = idx_q;
        pkt_valid_d = pkt_valid_q;
        pkt_cmd_d   = pkt_cmd_q;
        pkt_len_d   = pkt_len_q;
        err_chk_d   = 1'b0;
        err_len_d   = 1'b0;
        drop_d      = 1'b0;
        wr_en_c     = 1'b0;
        wr_addr_c   = ADDR_W'(idx_q);

        if (timeout_c) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        sum_d   = 8'd0;
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (i_Rx_DV) begin
                        cmd_d   = i_Rx_Byte;
                        sum_d   = sum_next_c;
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte > MAX_LEN_B) begin
                            err_len_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            len_d   = i_Rx_Byte;
                            sum_d   = sum_next_c;
                            idx_d   = 8'd0;
                            state_d = (i_Rx_Byte == 8'd0) ? S_CHK : S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (i_Rx_DV) begin
                        wr_en_c = 1'b1;
                        sum_d   = sum_next_c;
                        idx_d   = idx_q + 8'd1;
                        if (8'(idx_q + 8'd1) == len_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (i_Rx_DV) begin
                        if (sum_next_c == 8'd0) begin
                            pkt_valid_d = 1'b1;
                            pkt_cmd_d   = cmd_q;
                            pkt_len_d   = len_q;
                            state_d     = S_HOLD;
                        end else begin
                            err_chk_d = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    drop_d = i_Rx_DV;
                    if (i_Pkt_Ack) begin
                        pkt_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered buffer read; addresses past the buffer read as zero
    always_comb begin
        rd_data_d = 8'h00;
        if (32'(i_Rd_Addr) < MAX_LEN) begin
            rd_data_d = buf_mem[i_Rd_Addr];
        end
    end

    // Parser state and output registers
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_IDLE;
            sum_q       <= 8'd0;
            cmd_q       <= 8'd0;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            pkt_valid_q <= 1'b0;
            pkt_cmd_q   <= 8'd0;
            pkt_len_q   <= 8'd0;
            err_chk_q   <= 1'b0;
            err_len_q   <= 1'b0;
            drop_q      <= 1'b0;
            rd_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_cmd_q   <= pkt_cmd_d;
            pkt_len_q   <= pkt_len_d;
            err_chk_q   <= err_chk_d;
            err_len_q   <= err_len_d;
            drop_q      <= drop_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Payload buffer, deliberately without reset
    always_ff @(posedge i_Clock) begin
        if (wr_en_c) begin
            buf_mem[wr_addr_c] <= i_Rx_Byte;
        end
    end

    assign o_Rd_Data   = rd_data_q;
    assign o_Pkt_Valid = pkt_valid_q;
    assign o_Pkt_Cmd   = pkt_cmd_q;
    assign o_Pkt_Len   = pkt_len_q;
    assign o_Err_Chk   = err_chk_q;
    assign o_Err_Len   = err_len_q;
    assign o_Drop      = drop_q;

endmodule

// File: doc/uart_packet_rx.md
# uart_packet_rx

- Packet framer that sits directly downstream of the UART byte receiver.
- Consumes the receiver's one-cycle data-valid strobe and byte, then hunts for a sync byte and parses command, length, payload and checksum.
- Buffers the payload of a good packet and presents it to the user logic with a valid/ack handshake.
- Reports framing errors as one-cycle pulses.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, start-of-packet marker.
- MAX_LEN, 16, payload buffer depth in bytes (1..255).
- ADDR_W, 4, read-address width; must satisfy 2**ADDR_W >= MAX_LEN.
- TIMEOUT_CLKS, 43400, inter-byte timeout in clocks (≈10 byte times at 434 clks/bit); must be ≤ 65535.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Rx_DV  in  1  byte strobe from UART receiver, one cycle per byte.
- i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1.
- i_Pkt_Ack  in  1  user releases the current packet.
- i_Rd_Addr  in  ADDR_W  payload buffer read address.
- o_Rd_Data  out  8  payload byte at i_Rd_Addr, registered.
- o_Pkt_Valid  out  1  a checked packet is held.
- o_Pkt_Cmd  out  8  command byte of the held packet.
- o_Pkt_Len  out  8  payload length of the held packet.
- o_Err_Chk  out  1  checksum-mismatch pulse.
- o_Err_Len  out  1  length > MAX_LEN pulse.
- o_Err_Timeout  out  1  inter-byte timeout pulse.
- o_Drop  out  1  byte discarded because a packet is still held.

## Operation
Packet format:
- SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK.
- Valid when (CMD + LEN + Σpayload + CHK) mod 256 == 0.
- Running sum is 8-bit and wraps; it is cleared when SYNC is accepted.

State machine (state advances only on i_Rx_DV unless noted):
- S_IDLE: byte == SYNC_BYTE → S_CMD; any other byte is silently ignored.
- S_CMD: latch CMD, add to sum → S_LEN.
- S_LEN:
  - LEN > MAX_LEN → pulse o_Err_Len, → S_IDLE.
  - LEN == 0 → S_CHK.
  - Otherwise latch LEN, clear write index → S_PAYLOAD.
- S_PAYLOAD: write byte to buffer[index], add to sum, index+1; after the LEN-th byte → S_CHK. Payload bytes equal to SYNC_BYTE are data; there is no resync.
- S_CHK:
  - Sum good → update o_Pkt_Cmd/o_Pkt_Len, assert o_Pkt_Valid → S_HOLD.
  - Sum bad → pulse o_Err_Chk → S_IDLE.
- S_HOLD:
  - i_Pkt_Ack=1 → deassert o_Pkt_Valid → S_IDLE.
  - Any i_Rx_DV here pulses o_Drop and the byte is discarded, including a byte arriving in the ack cycle.

Other rules:
- i_Pkt_Ack outside S_HOLD is ignored.
- o_Pkt_Cmd/o_Pkt_Len and buffer contents stay stable while o_Pkt_Valid=1.
- Buffer:
  - MAX_LEN × 8, no reset.
  - Reads at address ≥ MAX_LEN return 8'h00.
  - Reads at address ≥ o_Pkt_Len return stale data.

Reset (asynchronous, any state, mid-packet included):
- State → S_IDLE; partial packet discarded.
- All outputs 0: o_Rd_Data, o_Pkt_Valid, o_Pkt_Cmd, o_Pkt_Len, all error pulses, o_Drop.
- Buffer contents undefined.

## Timing
- o_Pkt_Valid rises in the cycle after the i_Rx_DV cycle carrying CHK.
- o_Pkt_Valid falls in the cycle after i_Pkt_Ack is sampled high.
- o_Err_Chk, o_Err_Len, o_Drop:
  - Exactly one cycle high.
  - Asserted in the cycle after the offending i_Rx_DV.
- o_Rd_Data: 1-cycle latency from i_Rd_Addr; continuous reads, one per clock.
- Back-to-back i_Rx_DV on consecutive clocks is accepted; every strobe is processed.
- Timeout counter:
  - 16-bit; cleared on every i_Rx_DV; counts only in S_CMD, S_LEN, S_PAYLOAD, S_CHK.
  - On reaching TIMEOUT_CLKS-1: pulse o_Err_Timeout for one cycle → S_IDLE.
  - If i_Rx_DV arrives in that same cycle, the byte wins and no timeout occurs.

## Configuration
- Macro: UART_PKT_RX_TIMEOUT_EN.
- Defined: inter-byte timeout counter and o_Err_Timeout active as above.
- Undefined:
  - No counter is built; o_Err_Timeout is tied 0 (port kept).
  - A stalled partial packet waits indefinitely for bytes.

## Test plan
- A5 01 02 10 20 CD → o_Pkt_Valid=1, Cmd=01, Len=02; reading addr 0/1 gives 10/20 one cycle later; ack → Valid=0 next cycle.
- A5 01 02 10 20 CC → one-cycle o_Err_Chk, o_Pkt_Valid stays 0, Cmd/Len unchanged.
- A5 03 11 → one-cycle o_Err_Len (MAX_LEN=16); following A5 07 00 F9 → Valid, Cmd=07, Len=00.
- 00 FF 5A then A5 07 00 F9 → no errors on leading garbage, packet accepted.
- Good packet held; send A5 with no ack → o_Drop pulse, Valid stays 1; ack, then A5 02 01 33 CA → Valid, Cmd=02, buffer[0]=33.
- With UART_PKT_RX_TIMEOUT_EN: A5 01 then idle TIMEOUT_CLKS clocks → one o_Err_Timeout pulse; next A5 07 00 F9 accepted. Assert i_Rst_n=0 mid-payload → all outputs 0 immediately, then clean packet accepted.
